// File: rtl/parity_check_pkg.sv
// parity_check_pkg: shared state encoding, default width and parity function for the parity link
package parity_check_pkg;
  typedef enum logic {ST_RUN = 1'b0, ST_LOCKED = 1'b1} state_t;
  localparam int DATA_W_DEF = 5;
  // Words narrower than 32 bits are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic parity(input logic [31:0] w);
    return ^w;
  endfunction
endpackage

// File: rtl/parity_err_counter.sv
// parity_err_counter: saturating error counter with synchronous clear
module parity_err_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  // clear has priority; increments stop at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= clr ? '0 : (inc && !(&cnt)) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/parity_check.sv
// parity_check: even-parity word checker with error counting and consecutive-error lockout
module parity_check
  import parity_check_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CNT_W     = 8,
  parameter int ERR_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W:0]   rx_word,
  input  logic              rx_valid,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              locked
);
  state_t     state, state_nxt;
  logic [3:0] consec;
  logic       bad, take, run, hit;
  assign bad    = parity(32'(rx_word));
  assign take   = rx_valid && !clr_err;
  assign run    = state == ST_RUN;
  assign hit    = run && take && bad && (consec + 4'd1 == 4'(ERR_LIMIT));
  assign locked = state == ST_LOCKED;
  // lock on the limit-th consecutive bad word; only a clear returns to RUN
  always_comb state_nxt = clr_err ? ST_RUN : hit ? ST_LOCKED : state;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_RUN;
    else state <= state_nxt;
  // registered result pulses, data capture, sticky flag and consecutive-error run length
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      err_sticky <= 1'b0;
      consec     <= '0;
    end else begin
      data_valid <= take && !bad && run;
      parity_err <= take && bad;
      if (take && !bad && run) data_out <= rx_word[DATA_W:1];
      err_sticky <= !clr_err && (err_sticky || (take && bad));
      consec     <= clr_err ? '0 : (!run || !take) ? consec : bad ? consec + 4'd1 : '0;
    end
  parity_err_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(take && bad),
    .clr(clr_err),
    .cnt(err_cnt)
  );
endmodule

// File: doc/parity_check.md
Name: parity_check

Overview:
- Receive-side checker for the 5-bit even-parity word format: word = {data[4:0], p}, where p = XOR of the data bits, so a valid word has XOR of all 6 bits equal to 0.
- Each valid word is checked, and the data field is passed downstream with a one-cycle registered result.
- Errors are counted, and a run of consecutive errors locks the link until software clears it.
- Sits between the link/word capture logic and the data consumer.

Parameters:
- DATA_W, 5, data bits per word; the word is DATA_W+1 bits with parity in the LSB.
- CNT_W, 8, width of the saturating error counter.
- ERR_LIMIT, 4, number of consecutive parity errors that force the LOCKED state (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_word  in  DATA_W+1  received word {data, p}.
- rx_valid  in  1  rx_word is valid this cycle; single-cycle qualifier, no backpressure.
- clr_err  in  1  synchronous clear of err_cnt, err_sticky, the consecutive-error count and LOCKED.
- data_out  out  DATA_W  data field of the last accepted good word.
- data_valid  out  1  one-cycle pulse: data_out updated with a good word.
- parity_err  out  1  one-cycle pulse: the word checked this cycle had bad parity.
- err_sticky  out  1  set on any parity error, held until clr_err.
- err_cnt  out  CNT_W  total parity errors, saturating at all-ones.
- locked  out  1  high while in the LOCKED state.

Behaviour:
- Reset: rst is asynchronous, active-high. All outputs go to 0, the FSM goes to RUN, and the consecutive-error count goes to 0.
- Check: bad = ^rx_word (reduction XOR over all DATA_W+1 bits); evaluated only when rx_valid=1.
- Latency: the cycle after rx_valid is sampled, exactly one of data_valid or parity_err pulses. Both are 0 when rx_valid=0.
- Good word in RUN:
  - data_out <= rx_word[DATA_W:1]; data_valid <= 1.
  - Consecutive-error count <= 0.
- Bad word in RUN:
  - data_out holds its value; parity_err <= 1; err_sticky <= 1.
  - err_cnt increments unless it is all-ones (saturates, no wrap).
  - Consecutive-error count increments. If the new value equals ERR_LIMIT, go to LOCKED on the same edge.
- FSM has two states, RUN and LOCKED.
  - RUN -> LOCKED on the ERR_LIMIT-th consecutive bad word.
  - LOCKED -> RUN only on clr_err=1.
- In LOCKED:
  - Words are still checked; parity_err pulses and err_cnt counts on bad words.
  - data_valid never pulses and data_out holds.
  - locked = 1, asserted the cycle after the triggering word.
- clr_err (synchronous, one cycle):
  - err_cnt <= 0, err_sticky <= 0, consecutive-error count <= 0, FSM <= RUN.
- clr_err and rx_valid in the same cycle: the clear wins for the counters and sticky bit; the word is dropped.
  - No data_valid or parity_err pulse is generated for it, and err_cnt stays 0.
- Back-to-back rx_valid on every cycle is supported at full rate; each word produces its own pulse.
- Consecutive-error counter width is 4 bits; it never exceeds ERR_LIMIT.
- Reset asserted mid-stream: in-flight pulses are lost and no pulse is emitted after release until a new rx_valid arrives.

Decomposition:
- Shared package:
  - fsm state encoding (ST_RUN=1'b0, ST_LOCKED=1'b1).
  - Default DATA_W.
  - A parity function, so the generator and checker use one definition.
- One natural sub-module, parity_err_counter: the saturating CNT_W counter with inc/clr inputs, reusable elsewhere.
- Everything else stays in parity_check.

Test Plan:
- Reset then idle: rst pulse, rx_valid=0 for 10 cycles -> all outputs 0, locked=0.
- Good word: rx_word=6'b101101 (data 10110, p=1), rx_valid one cycle -> next cycle data_valid=1, data_out=5'b10110, parity_err=0, err_cnt=0.
- Single error: rx_word=6'b101100 -> next cycle parity_err=1, err_sticky=1, err_cnt=1, data_out unchanged (10110). A following good word 6'b000000 -> data_valid=1, data_out=0, err_sticky stays 1.
- Lockout: 4 back-to-back bad words 6'b000001 -> err_cnt=4, locked=1 the cycle after the 4th. Then good word 6'b000110 -> no data_valid. Then clr_err -> locked=0, err_cnt=0, err_sticky=0. Then good word 6'b000110 -> data_valid=1, data_out=5'b00011.
- Saturation: with CNT_W=3 and ERR_LIMIT=15, send 9 bad words -> err_cnt=7 and holds at 7.
- Clear collision and reset: clr_err with a bad word in the same cycle -> err_cnt=0, no parity_err pulse. Assert rst during a back-to-back stream -> outputs 0 asynchronously.
